// File: rtl/digital_input_scan_controller.sv
// digital_input_scan_controller
// Standalone sequencer for the main and expansion 16-bit parallel-in/serial-out
// TTL input chains. Generates serial_LOAD/serial_CLK at a rate set by CLK_DIV,
// assembles the serial streams plus two direct TTL inputs into 16-bit words,
// and reports each completed scan with a busy/done handshake.
// Optional feature: define DIGIN_SCAN_CHANGE_DETECT_EN to build sticky per-bit
// change flags (TTL_changed / TTL_changed_exp); otherwise they read as zero.
module digital_input_scan_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic        changed_clr,
    input  logic        serial_in,
    input  logic        serial_in_exp,
    input  logic        TTL_in_direct_1,
    input  logic        TTL_in_direct_2,
    output logic        serial_LOAD,
    output logic        serial_CLK,
    output logic [15:0] TTL_parallel,
    output logic [15:0] TTL_parallel_exp,
    output logic        busy,
    output logic        done,
    output logic [15:0] TTL_changed,
    output logic [15:0] TTL_changed_exp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    localparam logic [7:0] TIMER_RELOAD = 8'(CLK_DIV - 1);

    state_t      r_state;
    logic [7:0]  r_timer;
    logic [3:0]  r_k;
    logic [15:0] r_main_sh;
    logic [15:0] r_exp_sh;
    logic [15:0] r_ttl_par;
    logic [15:0] r_ttl_par_exp;
    logic        r_load_n;
    logic        r_sclk;
    logic        r_busy;
    logic        r_done;

    // Scan sequencer: state, pacing counters, shadow capture and registered outputs.
    // serial_LOAD/serial_CLK are written alongside each state transition so they
    // always equal a decode of the state register.
    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_timer       <= 8'd0;
            r_k           <= 4'd0;
            r_main_sh     <= 16'd0;
            r_exp_sh      <= 16'd0;
            r_ttl_par     <= 16'd0;
            r_ttl_par_exp <= 16'd0;
            r_load_n      <= 1'b1;
            r_sclk        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_load_n <= 1'b1;
                    r_sclk   <= 1'b0;
                    if (start) begin
                        r_state     <= S_LOAD;
                        r_timer     <= TIMER_RELOAD;
                        r_k         <= 4'd0;
                        r_busy      <= 1'b1;
                        r_exp_sh[0] <= TTL_in_direct_1;
                        r_exp_sh[1] <= TTL_in_direct_2;
                        r_load_n    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (r_timer == 8'd0) begin
                        r_state  <= S_SHIFT_LO;
                        r_timer  <= TIMER_RELOAD;
                        r_load_n <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_SHIFT_LO: begin
                    if (r_timer == 8'd0) begin
                        // Bits arrive MSB first; ~k == 15-k for a 4-bit index.
                        r_main_sh[~r_k] <= serial_in;
                        // Expansion bits 1:0 come from the direct inputs instead.
                        if (r_k <= 4'd13) begin
                            r_exp_sh[~r_k] <= serial_in_exp;
                        end
                        if (r_k == 4'd15) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT_HI;
                            r_timer <= TIMER_RELOAD;
                            r_sclk  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_SHIFT_HI: begin
                    if (r_timer == 8'd0) begin
                        r_k     <= r_k + 4'd1;
                        r_state <= S_SHIFT_LO;
                        r_timer <= TIMER_RELOAD;
                        r_sclk  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_DONE: begin
                    r_ttl_par     <= r_main_sh;
                    r_ttl_par_exp <= r_exp_sh;
                    r_done        <= 1'b1;
                    if (continuous) begin
                        r_state     <= S_LOAD;
                        r_timer     <= TIMER_RELOAD;
                        r_k         <= 4'd0;
                        r_exp_sh[0] <= TTL_in_direct_1;
                        r_exp_sh[1] <= TTL_in_direct_2;
                        r_load_n    <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_load_n <= 1'b1;
                    r_sclk   <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIGIN_SCAN_CHANGE_DETECT_EN
    logic [15:0] r_changed;
    logic [15:0] r_changed_exp;

    // Sticky change flags: compare each new word with the previous output word.
    // A clear coinciding with DONE keeps only the freshly detected changes.
    always_ff @(posedge dataclk) begin
        if (reset) begin
            r_changed     <= 16'd0;
            r_changed_exp <= 16'd0;
        end else if (r_state == S_DONE) begin
            if (changed_clr) begin
                r_changed     <= r_main_sh ^ r_ttl_par;
                r_changed_exp <= r_exp_sh ^ r_ttl_par_exp;
            end else begin
                r_changed     <= r_changed | (r_main_sh ^ r_ttl_par);
                r_changed_exp <= r_changed_exp | (r_exp_sh ^ r_ttl_par_exp);
            end
        end else if (changed_clr) begin
            r_changed     <= 16'd0;
            r_changed_exp <= 16'd0;
        end
    end

    assign TTL_changed     = r_changed;
    assign TTL_changed_exp = r_changed_exp;
`else
    logic w_unused_changed_clr;

    assign w_unused_changed_clr = changed_clr;
    assign TTL_changed          = 16'd0;
    assign TTL_changed_exp      = 16'd0;
`endif

    assign serial_LOAD      = r_load_n;
    assign serial_CLK       = r_sclk;
    assign TTL_parallel     = r_ttl_par;
    assign TTL_parallel_exp = r_ttl_par_exp;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule

// File: tb/tb_digital_input_scan_controller.sv
// Bench for digital_input_scan_controller: two instances (CLK_DIV=4 and 1),
// each driven by a behavioural model of a pair of 16-bit PISO chains.
module tb_digital_input_scan_controller;

    localparam int DA = 4;
    localparam int DB = 1;
`ifdef DIGIN_SCAN_CHANGE_DETECT_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif

    logic dataclk = 1'b0;
    logic reset, changed_clr, d1, d2;
    logic start_a, cont_a, sin_a, sexp_a, load_a, sclk_a, busy_a, done_a;
    logic start_b, cont_b, sin_b, sexp_b, load_b, sclk_b, busy_b, done_b;
    logic [15:0] par_a, pexp_a, chg_a, chgx_a;
    logic [15:0] par_b, pexp_b, chg_b, chgx_b;

    // chain models: parallel data presented, shift registers, previous CLK level
    logic [15:0] ch_main_a = 16'd0, ch_exp_a = 16'd0, sr_main_a = 16'd0, sr_exp_a = 16'd0;
    logic [15:0] ch_main_b = 16'd0, ch_exp_b = 16'd0, sr_main_b = 16'd0, sr_exp_b = 16'd0;
    logic        pclk_a = 1'b0, pclk_b = 1'b0;

    int vectors = 0;
    int errors  = 0;

    // reference state for the change-detect model
    logic [15:0] ref_prev_m, ref_prev_e, ref_chg_m, ref_chg_e;

    always #5 dataclk = ~dataclk;

    digital_input_scan_controller #(.CLK_DIV(DA)) u_dut_a (
        .dataclk(dataclk), .reset(reset), .start(start_a), .continuous(cont_a),
        .changed_clr(changed_clr), .serial_in(sin_a), .serial_in_exp(sexp_a),
        .TTL_in_direct_1(d1), .TTL_in_direct_2(d2),
        .serial_LOAD(load_a), .serial_CLK(sclk_a),
        .TTL_parallel(par_a), .TTL_parallel_exp(pexp_a),
        .busy(busy_a), .done(done_a),
        .TTL_changed(chg_a), .TTL_changed_exp(chgx_a)
    );

    digital_input_scan_controller #(.CLK_DIV(DB)) u_dut_b (
        .dataclk(dataclk), .reset(reset), .start(start_b), .continuous(cont_b),
        .changed_clr(changed_clr), .serial_in(sin_b), .serial_in_exp(sexp_b),
        .TTL_in_direct_1(d1), .TTL_in_direct_2(d2),
        .serial_LOAD(load_b), .serial_CLK(sclk_b),
        .TTL_parallel(par_b), .TTL_parallel_exp(pexp_b),
        .busy(busy_b), .done(done_b),
        .TTL_changed(chg_b), .TTL_changed_exp(chgx_b)
    );

    // PISO chains: load while LOAD is low, shift toward the output on CLK rise
    always @(negedge dataclk) begin
        if (!load_a) begin
            sr_main_a = ch_main_a;
            sr_exp_a  = ch_exp_a;
        end else if (sclk_a && !pclk_a) begin
            sr_main_a = sr_main_a << 1;
            sr_exp_a  = sr_exp_a << 1;
        end
        pclk_a = sclk_a;
        if (!load_b) begin
            sr_main_b = ch_main_b;
            sr_exp_b  = ch_exp_b;
        end else if (sclk_b && !pclk_b) begin
            sr_main_b = sr_main_b << 1;
            sr_exp_b  = sr_exp_b << 1;
        end
        pclk_b = sclk_b;
    end

    assign sin_a  = sr_main_a[15];
    assign sexp_a = sr_exp_a[15];
    assign sin_b  = sr_main_b[15];
    assign sexp_b = sr_exp_b[15];

    // One scan on instance A. Called right after a negedge; start is sampled on the
    // next rising edge (the accept edge). Sample n is taken at the n-th negedge after it.
    task automatic run_scan_a(input logic [15:0] m, input logic [15:0] e,
                              input logic dv1, input logic dv2,
                              input int s1, input int s2, input int clr_at,
                              output int lat, output int lo_cnt, output int pulses,
                              output int hi_min, output int hi_max, output int busy_cnt,
                              output int dones, output logic [15:0] pm, output logic [15:0] pe);
        int run;
        ch_main_a = m; ch_exp_a = e; d1 = dv1; d2 = dv2;
        start_a = 1'b1;
        lat = -1; lo_cnt = 0; pulses = 0; hi_min = 9999; hi_max = 0;
        busy_cnt = 0; dones = 0; run = 0; pm = 16'd0; pe = 16'd0;
        for (int n = 1; n <= 32 * DA + 12; n++) begin
            @(negedge dataclk);
            start_a     = (n == s1 || n == s2);
            changed_clr = (n == clr_at);
            // direct inputs move after accept; the captured values must not
            if (n == 2) begin d1 = ~dv1; d2 = ~dv2; end
            if (!load_a) lo_cnt++;
            if (busy_a) busy_cnt++;
            if (sclk_a) run++;
            else if (run > 0) begin
                pulses++;
                if (run < hi_min) hi_min = run;
                if (run > hi_max) hi_max = run;
                run = 0;
            end
            if (done_a) begin
                dones++;
                if (lat < 0) begin lat = n - 1; pm = par_a; pe = pexp_a; end
            end
        end
        start_a = 1'b0; changed_clr = 1'b0;
    endtask

    // change-detect reference: flags accumulate new^previous word; clear at DONE keeps new only
    task automatic model_done(input logic [15:0] nm, input logic [15:0] ne, input bit clr);
        logic [15:0] xm, xe;
        xm = nm ^ ref_prev_m;
        xe = ne ^ ref_prev_e;
        ref_chg_m  = clr ? xm : (ref_chg_m | xm);
        ref_chg_e  = clr ? xe : (ref_chg_e | xe);
        ref_prev_m = nm;
        ref_prev_e = ne;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge dataclk);
        vectors++; if (load_a !== 1'b1) begin errors++; $display("FAIL reset_load: got %b want 1", load_a); end
        vectors++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b want 0", sclk_a); end
        vectors++; if ({par_a, pexp_a} !== 32'd0) begin errors++; $display("FAIL reset_words: got %h want 0", {par_a, pexp_a}); end
        vectors++; if ({busy_a, done_a, busy_b, done_b} !== 4'd0) begin errors++; $display("FAIL reset_handshake: got %b want 0000", {busy_a, done_a, busy_b, done_b}); end
        vectors++; if ({chg_a, chgx_a} !== 32'd0) begin errors++; $display("FAIL reset_changed: got %h want 0", {chg_a, chgx_a}); end
        reset = 1'b0;
        ref_prev_m = 16'd0; ref_prev_e = 16'd0; ref_chg_m = 16'd0; ref_chg_e = 16'd0;
        @(negedge dataclk);
    endtask

    task automatic test_single_scan;
        int lat, lo, pul, hmin, hmax, bc, nd;
        logic [15:0] pm, pe;
        run_scan_a(16'hA5C3, {14'h2AAA, 2'b00}, 1'b1, 1'b0, -1, -1, -1,
                   lat, lo, pul, hmin, hmax, bc, nd, pm, pe);
        model_done(16'hA5C3, 16'hAAA9, 1'b0);
        vectors++; if (lat !== 32 * DA + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, 32 * DA + 1); end
        vectors++; if (lo !== DA) begin errors++; $display("FAIL single_load_width: got %0d want %0d", lo, DA); end
        vectors++; if (pul !== 15) begin errors++; $display("FAIL single_clk_pulses: got %0d want 15", pul); end
        vectors++; if (hmin !== DA || hmax !== DA) begin errors++; $display("FAIL single_clk_width: got %0d..%0d want %0d", hmin, hmax, DA); end
        vectors++; if (bc !== 32 * DA + 1) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", bc, 32 * DA + 1); end
        vectors++; if (pm !== 16'hA5C3) begin errors++; $display("FAIL single_main: got %h want a5c3", pm); end
        vectors++; if (pe !== 16'hAAA9) begin errors++; $display("FAIL single_exp: got %h want aaa9", pe); end
        vectors++; if ({chg_a, chgx_a} !== (CD_EN ? {ref_chg_m, ref_chg_e} : 32'd0)) begin errors++; $display("FAIL single_changed: got %h want %h", {chg_a, chgx_a}, CD_EN ? {ref_chg_m, ref_chg_e} : 32'd0); end
    endtask

    task automatic test_random_scans;
        int lat, lo, pul, hmin, hmax, bc, nd;
        logic [15:0] pm, pe, m, e, ee;
        logic v1, v2;
        for (int i = 0; i < 4; i++) begin
            m = 16'($urandom); e = 16'($urandom);
            v1 = 1'($urandom); v2 = 1'($urandom);
            ee = {e[15:2], v2, v1};
            run_scan_a(m, e, v1, v2, -1, -1, -1, lat, lo, pul, hmin, hmax, bc, nd, pm, pe);
            model_done(m, ee, 1'b0);
            vectors++; if (pm !== m) begin errors++; $display("FAIL rand_main[%0d]: got %h want %h", i, pm, m); end
            vectors++; if (pe !== ee) begin errors++; $display("FAIL rand_exp[%0d]: got %h want %h", i, pe, ee); end
            vectors++; if (nd !== 1 || lat !== 32 * DA + 1) begin errors++; $display("FAIL rand_done[%0d]: got %0d pulses lat %0d want 1 lat %0d", i, nd, lat, 32 * DA + 1); end
            // words must hold after the scan
            vectors++; if (par_a !== m) begin errors++; $display("FAIL rand_hold[%0d]: got %h want %h", i, par_a, m); end
        end
    endtask

    task automatic test_ignored_start;
        int lat, lo, pul, hmin, hmax, bc, nd;
        logic [15:0] pm, pe, m;
        m = 16'($urandom);
        // second start mid-scan, third on the DONE edge (sample 32*DA+1)
        run_scan_a(m, 16'h0000, 1'b0, 1'b0, 50, 32 * DA + 1, -1,
                   lat, lo, pul, hmin, hmax, bc, nd, pm, pe);
        model_done(m, 16'h0000, 1'b0);
        vectors++; if (nd !== 1) begin errors++; $display("FAIL ignored_done_count: got %0d want 1", nd); end
        vectors++; if (lo !== DA) begin errors++; $display("FAIL ignored_second_load: got %0d low cycles want %0d", lo, DA); end
        vectors++; if (bc !== 32 * DA + 1) begin errors++; $display("FAIL ignored_busy_len: got %0d want %0d", bc, 32 * DA + 1); end
        vectors++; if (pm !== m) begin errors++; $display("FAIL ignored_main: got %h want %h", pm, m); end
    endtask

    task automatic test_reset_mid_scan;
        int lat, lo, pul, hmin, hmax, bc, nd;
        logic [15:0] pm, pe, m, e;
        ch_main_a = 16'hFFFF; ch_exp_a = 16'hFFFF;
        start_a = 1'b1;
        // SHIFT_HI with k=7 spans samples 16*DA+1 .. 17*DA
        for (int n = 1; n <= 16 * DA + 2; n++) begin
            @(negedge dataclk);
            start_a = 1'b0;
        end
        vectors++; if (sclk_a !== 1'b1) begin errors++; $display("FAIL midreset_phase: got clk %b want 1", sclk_a); end
        reset = 1'b1;
        @(negedge dataclk);
        reset = 1'b0;
        vectors++; if ({load_a, sclk_a, busy_a} !== 3'b100) begin errors++; $display("FAIL midreset_ctrl: got %b want 100", {load_a, sclk_a, busy_a}); end
        vectors++; if ({par_a, pexp_a} !== 32'd0) begin errors++; $display("FAIL midreset_words: got %h want 0", {par_a, pexp_a}); end
        ref_prev_m = 16'd0; ref_prev_e = 16'd0; ref_chg_m = 16'd0; ref_chg_e = 16'd0;
        @(negedge dataclk);
        m = 16'($urandom); e = 16'($urandom);
        run_scan_a(m, e, 1'b1, 1'b1, -1, -1, -1, lat, lo, pul, hmin, hmax, bc, nd, pm, pe);
        model_done(m, {e[15:2], 2'b11}, 1'b0);
        vectors++; if ({pm, pe} !== {m, e[15:2], 2'b11}) begin errors++; $display("FAIL midreset_rescan: got %h want %h", {pm, pe}, {m, e[15:2], 2'b11}); end
    endtask

    task automatic test_continuous;
        int t[$];
        int n_drop;
        logic [15:0] m, e;
        m = 16'($urandom); e = 16'($urandom);
        ch_main_b = m; ch_exp_b = e; d1 = 1'b0; d2 = 1'b1;
        cont_b = 1'b1; start_b = 1'b1;
        n_drop = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge dataclk);
            start_b = 1'b0;
            if (done_b) begin
                t.push_back(n - 1);
                vectors++; if ({par_b, pexp_b} !== {m, e[15:2], 2'b10}) begin errors++; $display("FAIL cont_data[%0d]: got %h want %h", t.size(), {par_b, pexp_b}, {m, e[15:2], 2'b10}); end
                if (t.size() == 4) n_drop = n + 10;
            end
            if (n == n_drop) cont_b = 1'b0;
        end
        vectors++; if (t.size() !== 5) begin errors++; $display("FAIL cont_done_count: got %0d want 5", t.size()); end
        if (t.size() >= 1) begin
            vectors++; if (t[0] !== 32 * DB + 1) begin errors++; $display("FAIL cont_first_lat: got %0d want %0d", t[0], 32 * DB + 1); end
        end
        for (int i = 1; i < t.size(); i++) begin
            vectors++; if (t[i] - t[i-1] !== 32 * DB + 1) begin errors++; $display("FAIL cont_period[%0d]: got %0d want %0d", i, t[i] - t[i-1], 32 * DB + 1); end
        end
        vectors++; if ({busy_b, load_b, sclk_b} !== 3'b010) begin errors++; $display("FAIL cont_idle: got %b want 010", {busy_b, load_b, sclk_b}); end
    endtask

    task automatic test_change_detect;
        int lat, lo, pul, hmin, hmax, bc, nd;
        logic [15:0] pm, pe, e, want;
        logic [15:0] words [3];
        words[0] = 16'h0001; words[1] = 16'h0003; words[2] = 16'h0007;
        reset = 1'b1;
        @(negedge dataclk);
        reset = 1'b0;
        ref_prev_m = 16'd0; ref_prev_e = 16'd0; ref_chg_m = 16'd0; ref_chg_e = 16'd0;
        @(negedge dataclk);
        for (int i = 0; i < 3; i++) begin
            e = 16'($urandom);
            run_scan_a(words[i], e, 1'b0, 1'b0, -1, -1, (i == 2) ? 32 * DA + 1 : -1,
                       lat, lo, pul, hmin, hmax, bc, nd, pm, pe);
            model_done(words[i], {e[15:2], 2'b00}, i == 2);
            want = CD_EN ? ref_chg_m : 16'd0;
            vectors++; if (chg_a !== want) begin errors++; $display("FAIL chg_main[%0d]: got %h want %h", i, chg_a, want); end
            want = CD_EN ? ref_chg_e : 16'd0;
            vectors++; if (chgx_a !== want) begin errors++; $display("FAIL chg_exp[%0d]: got %h want %h", i, chgx_a, want); end
        end
        changed_clr = 1'b1;
        @(negedge dataclk);
        changed_clr = 1'b0;
        vectors++; if ({chg_a, chgx_a} !== 32'd0) begin errors++; $display("FAIL chg_clear: got %h want 0", {chg_a, chgx_a}); end
    endtask

    initial begin
        reset = 1'b1; changed_clr = 1'b0; d1 = 1'b0; d2 = 1'b0;
        start_a = 1'b0; cont_a = 1'b0; start_b = 1'b0; cont_b = 1'b0;
        @(negedge dataclk);
        test_reset;
        test_single_scan;
        test_random_scans;
        test_ignored_start;
        test_reset_mid_scan;
        test_continuous;
        test_change_detect;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/digital_input_scan_controller.md
# digital_input_scan_controller

Standalone sequencer for the two daisy-chained 16-bit parallel-in/serial-out TTL input shift registers (main and expansion). It generates `serial_LOAD`/`serial_CLK` at a programmable rate, independent of the main acquisition state machine. It captures the serial streams plus the two direct TTL inputs into 16-bit words and reports each completed scan with a busy/done handshake. It sits beside the digital input path so TTL inputs can be scanned between acquisition frames or while acquisition is stopped.

## Interface
- `CLK_DIV`, default 4: half-period of `serial_CLK`, and the duration of the LOAD pulse, in `dataclk` cycles. Legal range 1..255.
- `dataclk` input 1: sole clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: scan request; sampled only in IDLE.
- `continuous` input 1: when high, a new scan begins immediately after each DONE.
- `changed_clr` input 1: one-cycle pulse that clears the sticky change flags.
- `serial_in` input 1: main chain serial data.
- `serial_in_exp` input 1: expansion chain serial data.
- `TTL_in_direct_1` input 1: direct TTL input, captured into expansion bit 0.
- `TTL_in_direct_2` input 1: direct TTL input, captured into expansion bit 1.
- `serial_LOAD` output 1: active-low parallel load to both chains.
- `serial_CLK` output 1: shift clock to both chains.
- `TTL_parallel` output 16: last completed main-chain word.
- `TTL_parallel_exp` output 16: last completed expansion word.
- `busy` output 1: high from start-accept until DONE inclusive.
- `done` output 1: one-cycle pulse when the output words update.
- `TTL_changed` output 16: sticky per-bit change flags, main chain (macro-dependent).
- `TTL_changed_exp` output 16: sticky per-bit change flags, expansion chain (macro-dependent).

## Operation
- **Reset values:** `serial_LOAD`=1, `serial_CLK`=0, `TTL_parallel`=0, `TTL_parallel_exp`=0, `busy`=0, `done`=0, both change vectors =0. State returns to IDLE, and any partially captured words are discarded.
- **States:** IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE. A down-counter `timer` (8 bits) and a bit index `k` (4 bits, 0..15) pace the sequence.
- **IDLE:** outputs are LOAD=1, CLK=0.
  - `start`=1 leads to LOAD. On that same edge, `timer` is set to CLK_DIV-1, `k`=0, `busy`=1, and `TTL_in_direct_1`/`TTL_in_direct_2` are latched into shadow bits exp[0]/exp[1].
- **LOAD:** LOAD=0, CLK=0. When `timer`=0, go to SHIFT_LO and reload `timer`.
- **SHIFT_LO:** LOAD=1, CLK=0. When `timer`=0:
  - Sample `serial_in` into shadow main[15-k].
  - If k≤13, also sample `serial_in_exp` into shadow exp[15-k].
  - If k=15, go to DONE; otherwise go to SHIFT_HI and reload `timer`.
- **SHIFT_HI:** LOAD=1, CLK=1. When `timer`=0, increment `k`, go to SHIFT_LO and reload `timer`.
- **DONE (one cycle):** copy the shadow words to `TTL_parallel`/`TTL_parallel_exp`, `done`=1, LOAD=1, CLK=0.
  - If `continuous`=1, go to LOAD with the same setup as a start-accept (`busy` stays 1).
  - Otherwise go to IDLE and `busy`=0.
- **`start` handling:** asserted in any state other than IDLE, it is ignored (not queued). `start` in the DONE cycle is also ignored.
- **`continuous` deasserted mid-scan:** the current scan completes, then the block returns to IDLE.
- **Output word stability:** the output words change only in DONE and hold between scans.

## Timing
- **Output drive:** `serial_LOAD`/`serial_CLK` are registered and are a pure function of the registered state.
- **First edge:** LOAD falls on the first edge after start-accept.
- **LOAD pulse:** exactly CLK_DIV cycles low.
- **`serial_CLK` pulses:** exactly 15 high pulses per scan, each CLK_DIV cycles high, separated by CLK_DIV-cycle low phases.
- **Sampling point:** each bit is sampled on the last cycle of its low phase, i.e. CLK_DIV-1 cycles after the preceding falling/rising LOAD/CLK edge. This gives maximum setup at the chains.
- **Scan latency:** `done` is asserted 32·CLK_DIV+1 cycles after the start-accept edge. Output words are valid in the same cycle as `done`.
- **Continuous mode:** scan period is 32·CLK_DIV+1 cycles, with LOAD falling on the edge after DONE.
- **CLK_DIV=1:** legal. Every phase lasts one cycle.

## Configuration
- **Macro:** `DIGIN_SCAN_CHANGE_DETECT_EN`.
- **Defined:**
  - In DONE, `TTL_changed |= new_main ^ TTL_parallel` and `TTL_changed_exp |= new_exp ^ TTL_parallel_exp`. The comparison is against the previous output word, so the first scan after reset compares against 0.
  - `changed_clr` zeroes both vectors.
  - If `changed_clr` and DONE coincide, the new XOR result is loaded and the old flags are dropped: set wins over clear for new changes.
- **Undefined:** both change vectors are tied to 0, `changed_clr` is ignored, and no change-detect registers are synthesized.

## Test plan
- **Single scan:** CLK_DIV=4; chain presents main=16'hA5C3, exp serial bits 15..2 = 14'h2AAA, direct_1=1, direct_2=0. Pulse `start` → LOAD low 4 cycles, 15 CLK pulses of 4 cycles high; `done` 129 cycles after accept; `TTL_parallel`=16'hA5C3, `TTL_parallel_exp`=16'hAAA9.
- **Ignored start:** pulse `start` at cycle 50 of a scan and again in the DONE cycle → exactly one `done`; `busy` falls on the edge after DONE; no second LOAD.
- **Continuous mode:** `continuous`=1, CLK_DIV=1 → `done` pulses every 33 cycles. Drop `continuous` mid-scan → one more `done`, then IDLE with `busy`=0.
- **Reset mid-scan:** assert `reset` during SHIFT_HI at k=7 → next cycle `serial_CLK`=0, `serial_LOAD`=1, words =0, `busy`=0. A following scan returns correct data.
- **Change detect** (`DIGIN_SCAN_CHANGE_DETECT_EN` defined):
  - Scan 16'h0001 → `TTL_changed`=16'h0001.
  - Scan 16'h0003 → `TTL_changed`=16'h0003.
  - `changed_clr` coincident with DONE of a scan reading 16'h0007 → 16'h0004.
  - Macro undefined → `TTL_changed` stays 0.
